// File: rtl/pe_array_drain.sv
// Drain controller for the systolic PE array: shifts each column's mac chain
// into a ROWSxCOLS tile buffer, clears the PEs, then streams the tile row-major.
// Optional leaky-ReLU output transform is enabled by defining DRAIN_LEAKY_EN.

module pe_drain_col #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int RW         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic [RW-1:0]         cap_row,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [RW-1:0]         rd_row,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [ROWS-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mem <= '0;
    else if (cap_en) mem[cap_row] <= din;
  end

  assign dout = mem[rd_row];
endmodule

module pe_array_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tile_done,
  output logic                       tile_ready,
  input  logic [COLS*DATA_WIDTH-1:0] chain_in,
  output logic                       write_out_en,
  output logic                       reset_pe,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SHIFT, STREAM} state_t;
  state_t state;

  logic [RW-1:0] k, row_cnt;
  logic [CW-1:0] col_cnt;

  logic [COLS-1:0][DATA_WIDTH-1:0] col_in, col_word;
  logic                            cap_en;
  logic [RW-1:0]                   cap_row;

  assign col_in  = chain_in;
  assign cap_en  = (state == SHIFT);
  // Chain emerges tail-first: shift k carries row ROWS-1-k.
  assign cap_row = R_LAST - k;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    pe_drain_col #(.DATA_WIDTH(DATA_WIDTH), .ROWS(ROWS), .RW(RW)) u_col (
      .clk    (clk),
      .rst_n  (rst_n),
      .cap_en (cap_en),
      .cap_row(cap_row),
      .din    (col_in[c]),
      .rd_row (row_cnt),
      .dout   (col_word[c])
    );
  end

  logic [DATA_WIDTH-1:0] raw, xf;
  assign raw = col_word[col_cnt];

`ifdef DRAIN_LEAKY_EN
  logic signed [DATA_WIDTH-1:0] raw_s, leak_s;
  assign raw_s  = raw;
  assign leak_s = raw_s >>> 3;
  assign xf     = raw[DATA_WIDTH-1] ? DATA_WIDTH'(leak_s) : raw;
`else
  assign xf = raw;
`endif

  // Stream outputs decode from registered state/counters only.
  assign out_data = out_valid ? xf : '0;
  assign out_last = out_valid && (row_cnt == R_LAST) && (col_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      k            <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      tile_ready   <= 1'b1;
      write_out_en <= 1'b0;
      reset_pe     <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (tile_done) begin
          state      <= SETTLE;
          tile_ready <= 1'b0;
        end
        SETTLE: begin
          state        <= SHIFT;
          k            <= '0;
          write_out_en <= 1'b1;
          reset_pe     <= (ROWS == 1);
        end
        SHIFT: begin
          if (k == R_LAST) begin
            state        <= STREAM;
            write_out_en <= 1'b0;
            reset_pe     <= 1'b0;
            out_valid    <= 1'b1;
            row_cnt      <= '0;
            col_cnt      <= '0;
          end else begin
            k        <= k + RW'(1);
            reset_pe <= ((k + RW'(1)) == R_LAST);
          end
        end
        STREAM: if (out_ready) begin
          if (col_cnt == C_LAST) begin
            col_cnt <= '0;
            if (row_cnt == R_LAST) begin
              state      <= IDLE;
              out_valid  <= 1'b0;
              tile_ready <= 1'b1;
              row_cnt    <= '0;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end else begin
            col_cnt <= col_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_array_drain.sv
// Scoreboard bench for pe_array_drain: a tail-PE chain model feeds the drain,
// expected words are queued per tile and a negedge monitor compares each beat.

module tb_pe_array_drain;
  localparam int DW   = 16;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int NB   = ROWS * COLS;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tile_done;
  logic               tile_ready;
  logic [COLS*DW-1:0] chain_in;
  logic               write_out_en;
  logic               reset_pe;
  logic [DW-1:0]      out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  pe_array_drain #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tile_done   (tile_done),
    .tile_ready  (tile_ready),
    .chain_in    (chain_in),
    .write_out_en(write_out_en),
    .reset_pe    (reset_pe),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;
  int beat_idx = 0, weo_run = 0, rpe_run = 0;
  int rdy_mode = 0, hold = 0;
  logic [DW-1:0] mat [ROWS][COLS];
  int sh;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] w);
`ifdef DRAIN_LEAKY_EN
    int s;
    s = $signed(w);
    if (s < 0) s = -((-s + 7) / 8);
    return s[DW-1:0];
`else
    return w;
`endif
  endfunction

  // Tail-PE chain: each shift cycle presents the next row up, tail row first.
  always_comb begin
    for (int c = 0; c < COLS; c++)
      chain_in[c*DW +: DW] = (sh < ROWS) ? mat[ROWS-1-sh][c] : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            sh <= 0;
    else if (write_out_en) sh <= reset_pe ? 0 : sh + 1;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (beat_idx == 5 && hold < 3) begin
          out_ready = 1'b0;
          hold++;
        end else begin
          out_ready = 1'b1;
        end
      end
    endcase
    if (rdy_mode != 2) hold = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      beat_idx = 0;
      weo_run  = 0;
      rpe_run  = 0;
    end else begin
      if (write_out_en) weo_run++;
      if (reset_pe) begin
        rpe_run++;
        check("reset_pe_with_weo", {31'b0, write_out_en}, 1);
        check("reset_pe_on_last_shift", weo_run, ROWS);
      end
      if (!write_out_en && weo_run != 0) begin
        check("weo_length", weo_run, ROWS);
        check("reset_pe_length", rpe_run, 1);
        weo_run = 0;
        rpe_run = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_beat", {31'b0, out_valid}, 0);
        end else begin
          check("out_data", {16'b0, out_data}, {16'b0, q[0].d});
          check("out_last", {31'b0, out_last}, {31'b0, q[0].l});
          if (out_ready) begin
            void'(q.pop_front());
            beat_idx = out_last ? 0 : beat_idx + 1;
          end
        end
      end
    end
  end

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mat[r][c] = DW'($urandom_range(0, 65535));
  endtask

  task automatic issue_tile();
    for (int b = 0; b < NB; b++) begin
      exp_t e;
      e.d = model(mat[b / COLS][b % COLS]);
      e.l = (b == NB - 1);
      q.push_back(e);
    end
    @(posedge clk); #1 tile_done = 1'b1;
    @(posedge clk); #1 tile_done = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!tile_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tile_ready_wait", {31'b0, tile_ready}, 1);
  endtask

  task automatic run_tile(input int rmode, input bit ign, input bit timed);
    int first_v = 0, done_c = 0;
    bit extra = 0;
    rdy_mode = rmode;
    wait_ready();
    issue_tile();
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("busy_after_done", {31'b0, tile_ready}, 0);
      if (ign && (cyc == 3 || cyc == ROWS + 4)) tile_done = 1'b1;
      if (ign && (cyc == 4 || cyc == ROWS + 5)) tile_done = 1'b0;
      if (out_valid && first_v == 0) first_v = cyc;
      if (tile_ready && cyc > 1) begin
        done_c = cyc;
        break;
      end
    end
    check("tile_complete", {31'b0, tile_ready}, 1);
    if (timed) begin
      check("first_valid_latency", first_v, ROWS + 2);
      check("tile_period", done_c, ROWS + NB + 2);
    end
    check("queue_drained", q.size(), 0);
    if (ign) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (out_valid || !tile_ready) extra = 1;
      end
      check("no_second_tile", {31'b0, extra}, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tile_done = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mat[r][c] = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_tile_ready", {31'b0, tile_ready}, 1);
    check("rst_write_out_en", {31'b0, write_out_en}, 0);
    check("rst_reset_pe", {31'b0, reset_pe}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_last", {31'b0, out_last}, 0);
    check("rst_out_data", {16'b0, out_data}, 0);

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) mat[r][c] = DW'(16 * r + c);
    run_tile(0, 0, 1);
    run_tile(2, 0, 0);

    fill_random();
    run_tile(1, 1, 0);
    for (int t = 0; t < 5; t++) begin
      fill_random();
      run_tile(1, 0, 0);
    end

`ifdef DRAIN_LEAKY_EN
    fill_random();
    mat[0][0] = 16'hFFF0;
    mat[0][1] = 16'h0040;
    mat[2][3] = 16'h8000;
    run_tile(0, 0, 1);
`endif

    // Asynchronous reset in the middle of the stream.
    begin
      int n = 0;
      rdy_mode = 0;
      fill_random();
      wait_ready();
      issue_tile();
      while (!(beat_idx == 7 && out_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("reach_beat7", beat_idx, 7);
      #1 rst_n = 1'b0;
      q.delete();
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 0);
      check("mid_rst_out_last", {31'b0, out_last}, 0);
      check("mid_rst_out_data", {16'b0, out_data}, 0);
      check("mid_rst_tile_ready", {31'b0, tile_ready}, 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_tile_ready", {31'b0, tile_ready}, 1);
      check("post_rst_out_valid", {31'b0, out_valid}, 0);
    end

    fill_random();
    run_tile(1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pe_array_drain.md
# pe_array_drain

Drain controller at the bottom edge of the systolic PE array. Once a tile's accumulation completes, it shifts every column's mac chain out through the PEs' `write_out_en` path, buffers the full ROWS×COLS result tile, and clears the accumulators. It then streams the tile row-major to the output writer over a valid/ready interface. It is the reader of the mac_out chain the PEs write.

## Interface
- `DATA_WIDTH`, 16: word width; matches PE data width.
- `ROWS`, 4: PEs per column, which is the mac chain length.
- `COLS`, 4: number of columns drained in parallel.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tile_done` in 1: the array's final accumulation is already in the PE `result` registers; sampled only while `tile_ready` is high.
- `tile_ready` out 1: drain is idle and accepts `tile_done`.
- `chain_in` in COLS*DATA_WIDTH: mac_out of each column's tail PE (row ROWS-1). Column c occupies `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `write_out_en` out 1: broadcast to all PEs; high selects chain shift.
- `reset_pe` out 1: broadcast to all PEs; clears accumulators.
- `out_data` out DATA_WIDTH: result word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: downstream accepts the word.
- `out_last` out 1: marks the final word of the tile (row ROWS-1, col COLS-1).

## Operation
- FSM states are IDLE, SETTLE, SHIFT and STREAM. All outputs are registered or decoded from state and counters only; no input-to-output combinational path exists.
- **IDLE:**
  - `tile_ready`=1.
  - `tile_done`=1 moves the FSM to SETTLE.
- **SETTLE:** lasts 1 cycle. It lets each PE load `mac_out` with its quantized result. Then go to SHIFT with `k`=0.
- **SHIFT:** lasts ROWS cycles, `k`=0..ROWS-1.
  - `write_out_en`=1 throughout.
  - At the end of cycle k, each column's `chain_in` is captured into `buf[ROWS-1-k][c]`. The first capture is row ROWS-1 and the last is row 0.
  - `reset_pe`=1 only when k==ROWS-1. After the SHIFT→STREAM edge, PE accumulators are zero and the array may start the next tile.
  - After k==ROWS-1, go to STREAM with beat index `b`=0.
- **STREAM:**
  - `out_valid`=1 and `out_data`=`buf[b/COLS][b%COLS]`.
  - `out_last`=1 when b==ROWS*COLS-1.
  - On `out_valid`&&`out_ready`, b increments.
  - On the last handshake, go to IDLE.
  - While `out_ready`=0, `out_data` and `out_last` hold stable.
- Buffer width is DATA_WIDTH. Values are stored unmodified; any output transform is applied on the stream side only.
- `tile_done` in any non-IDLE state is ignored; the controller must hold it until `tile_ready`.
- Asynchronous reset in any state forces IDLE and clears the counters, the buffer and all outputs. The array must also be reset or re-accumulated, because a partially drained tile is lost.

## Timing
- Reset values:
  - `tile_ready`=1.
  - `write_out_en`=0, `reset_pe`=0.
  - `out_valid`=0, `out_last`=0.
  - `out_data`=0.
- Sequence, with `tile_done` sampled high in cycle T:
  - Cycle T+1 is SETTLE.
  - Cycles T+2..T+1+ROWS are SHIFT, with `write_out_en`=1.
  - `reset_pe`=1 in cycle T+1+ROWS only.
  - The first `out_valid` is in cycle T+2+ROWS.
- With `out_ready` held at 1, the last beat is in cycle T+1+ROWS+ROWS*COLS and `tile_ready`=1 in the next cycle.
- Minimum tile-to-tile period: 2+ROWS+ROWS*COLS cycles.

## Configuration
- `DRAIN_LEAKY_EN`:
  - Defined: the STREAM output applies fixed-point leaky ReLU. A negative word outputs `word >>> 3` (arithmetic, slope 0.125); a non-negative word passes unchanged.
  - Undefined: words pass unchanged.
  - Either way the buffer contents and all timing are identical.

## Test plan
- Reset release with defaults: all outputs at reset values; `tile_ready`=1.
- ROWS=COLS=4, tail PEs model the chain. Load column c, row r with value 16·r+c, pulse `tile_done`, hold `out_ready`=1 -> 16 beats in order 0,1,2,…,0x33; `out_last` on the 16th; `write_out_en` high for exactly 4 cycles; `reset_pe` for exactly 1 cycle, coinciding with the 4th.
- Backpressure: drop `out_ready` for 3 cycles at beat 5 -> `out_data`=0x11 held stable; no beat lost or duplicated.
- `tile_done` pulsed during SHIFT and again during STREAM -> ignored; exactly one tile is emitted.
- `rst_n` asserted at STREAM beat 7 -> `out_valid` drops immediately; after release, state is IDLE with `tile_ready`=1.
- With `DRAIN_LEAKY_EN`, word 0xFFF0 (−16) -> outputs 0xFFFE (−2); word 0x0040 -> outputs 0x0040.
